// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared state encoding, bank ids and defaults for the ping-pong read side
package pingpong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD1  = 2'd1,
      ST_RD2  = 2'd2
   } pp_state_e;

   localparam logic BANK1 = 1'b0;
   localparam logic BANK2 = 1'b1;

   localparam int PP_DATA_W = 8;
   localparam int PP_DEPTH  = 100;
   localparam int PP_ADDR_W = 7;

   function automatic logic [1:0] pp_popcnt2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/pp_skid_buf.sv
// rtl/pp_skid_buf.sv - 2-entry output buffer; RAM data bypasses straight to the output when empty
// The upstream side cannot stall (RAM data lives one cycle), so any unaccepted word is always stored.
module pp_skid_buf
   import pingpong_pkg::*;
#(
   parameter int DATA_W = PP_DATA_W
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_s_tdata,
   input  logic              i_s_tvalid,
   input  logic              i_s_tlast,
   output logic [DATA_W-1:0] o_m_tdata,
   output logic              o_m_tvalid,
   output logic              o_m_tlast,
   input  logic              i_m_tready,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_data [2];
   logic [1:0]        r_last;
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_count;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   always_comb begin
      w_empty = (r_count == 2'd0);
      w_pop   = !w_empty && i_m_tready;
      w_push  = i_s_tvalid && !(w_empty && i_m_tready);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_last    <= '0;
         r_rd_ptr  <= 1'b0;
         r_wr_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_data[r_wr_ptr] <= i_s_tdata;
            r_last[r_wr_ptr] <= i_s_tlast;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign o_m_tvalid = !w_empty || i_s_tvalid;
   assign o_m_tdata  = w_empty ? i_s_tdata : r_data[r_rd_ptr];
   assign o_m_tlast  = w_empty ? i_s_tlast : r_last[r_rd_ptr];
   assign o_count    = r_count;

endmodule

// File: rtl/pingpong_rd_ctrl.sv
// rtl/pingpong_rd_ctrl.sv - read side of the ping-pong buffer: drains RAM1/RAM2 alternately into a stream
// Optional overrun counter on err_cnt when PP_ERR_CNT_EN is defined; otherwise err_cnt is tied to zero.
module pingpong_rd_ctrl
   import pingpong_pkg::*;
#(
   parameter int DATA_W = PP_DATA_W,
   parameter int DEPTH  = PP_DEPTH,
   parameter int ADDR_W = PP_ADDR_W
)(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [1:0]        bank_full_i,
   output logic [1:0]        bank_free_o,
   output logic              ram1_rd_en,
   output logic [ADDR_W-1:0] ram1_rd_addr,
   input  logic [DATA_W-1:0] ram1_rd_data,
   output logic              ram2_rd_en,
   output logic [ADDR_W-1:0] ram2_rd_addr,
   input  logic [DATA_W-1:0] ram2_rd_data,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_last,
   output logic              active_bank,
   output logic [7:0]        err_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   pp_state_e         r_state;
   pp_state_e         w_state_nxt;
   logic [1:0]        r_pending;
   logic [1:0]        w_pending_nxt;
   logic [1:0]        r_free;
   logic              r_next_bank;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rd_done;
   logic              r_infl;
   logic              r_infl_bank;
   logic              r_infl_last;
   logic [1:0]        w_buf_count;
   logic              w_reading;
   logic              w_rd_bank;
   logic              w_issue;
   logic              w_accept;
   logic              w_bank_done;
   logic [DATA_W-1:0] w_s_data;
   logic              w_s_last;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Issue only while buffered plus in-flight words stay below the buffer depth, so nothing is ever lost.
   always_comb begin
      w_state_nxt  = r_state;
      w_reading    = (r_state != ST_IDLE);
      w_rd_bank    = (r_state == ST_RD2);
      w_issue      = w_reading && !r_rd_done &&
                     (({1'b0, w_buf_count} + {2'b00, r_infl}) < 3'd2);
      w_accept     = dout_valid && dout_ready;
      w_bank_done  = w_reading && w_accept && dout_last;
      ram1_rd_en   = w_issue && (w_rd_bank == BANK1);
      ram2_rd_en   = w_issue && (w_rd_bank == BANK2);
      ram1_rd_addr = ram1_rd_en ? r_addr : '0;
      ram2_rd_addr = ram2_rd_en ? r_addr : '0;
      case (r_state)
         ST_IDLE: begin
            if (r_pending[0] && (r_next_bank == BANK1)) begin
               w_state_nxt = ST_RD1;
            end else if (r_pending[1] && (r_next_bank == BANK2)) begin
               w_state_nxt = ST_RD2;
            end
         end
         ST_RD1, ST_RD2: begin
            if (w_bank_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_pending_nxt = bank_full_i | (r_pending & ~r_free);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pending   <= 2'b00;
         r_free      <= 2'b00;
         r_next_bank <= BANK1;
         r_addr      <= '0;
         r_rd_done   <= 1'b0;
         r_infl      <= 1'b0;
         r_infl_bank <= 1'b0;
         r_infl_last <= 1'b0;
      end else begin
         r_pending   <= w_pending_nxt;
         r_free      <= 2'b00;
         r_infl      <= w_issue;
         r_infl_bank <= w_rd_bank;
         r_infl_last <= (r_addr == LAST_ADDR);
         if (w_bank_done) begin
            r_free      <= w_rd_bank ? 2'b10 : 2'b01;
            r_next_bank <= ~r_next_bank;
            r_addr      <= '0;
            r_rd_done   <= 1'b0;
         end else if (w_issue) begin
            if (r_addr == LAST_ADDR) begin
               r_rd_done <= 1'b1;
            end else begin
               r_addr <= r_addr + 1'b1;
            end
         end
      end
   end

   assign w_s_data = r_infl ? (r_infl_bank ? ram2_rd_data : ram1_rd_data) : '0;
   assign w_s_last = r_infl && r_infl_last;

   pp_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .i_clk      (sys_clk),
      .i_rst_n    (sys_rst_n),
      .i_s_tdata  (w_s_data),
      .i_s_tvalid (r_infl),
      .i_s_tlast  (w_s_last),
      .o_m_tdata  (dout),
      .o_m_tvalid (dout_valid),
      .o_m_tlast  (dout_last),
      .i_m_tready (dout_ready),
      .o_count    (w_buf_count)
   );

   assign bank_free_o = r_free;
   assign active_bank = r_next_bank;

`ifdef PP_ERR_CNT_EN
   logic [1:0] w_ovr;
   logic [8:0] w_err_sum;
   logic [7:0] r_err_cnt;

   // A refill report for a bank still pending is an overrun unless that bank is being freed this cycle.
   always_comb begin
      w_ovr     = bank_full_i & r_pending & ~r_free;
      w_err_sum = {1'b0, r_err_cnt} + {7'd0, pp_popcnt2(w_ovr)};
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_err_cnt <= 8'd0;
      end else begin
         r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pingpong_rd_ctrl.sv
// tb/tb_pingpong_rd_ctrl.sv - scoreboard bench for pingpong_rd_ctrl
module tb_pingpong_rd_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 100;
   localparam int AW    = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    bank_full = 2'b00;
   logic          dout_ready = 1'b1;
   logic [1:0]    bank_free_o;
   logic          ram1_rd_en, ram2_rd_en;
   logic [AW-1:0] ram1_rd_addr, ram2_rd_addr;
   logic [DW-1:0] ram1_q = '0, ram2_q = '0;
   logic [DW-1:0] dout;
   logic          dout_valid, dout_last, active_bank;
   logic [7:0]    err_cnt;

   typedef struct {logic [7:0] data; logic last; int cyc;} word_t;
   typedef struct {logic [1:0] val; int cyc;} free_t;

   word_t sb_q[$];
   free_t fr_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int en_cnt = 0;
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_dout = '0;
   logic prev_last = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM1 holds addr, RAM2 holds addr+128, so the source bank is visible in the data
   always @(posedge clk) begin
      if (ram1_rd_en) ram1_q <= {1'b0, ram1_rd_addr};
      if (ram2_rd_en) ram2_q <= {1'b1, ram2_rd_addr};
   end

   pingpong_rd_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .sys_clk      (clk),
      .sys_rst_n    (rst_n),
      .bank_full_i  (bank_full),
      .bank_free_o  (bank_free_o),
      .ram1_rd_en   (ram1_rd_en),
      .ram1_rd_addr (ram1_rd_addr),
      .ram1_rd_data (ram1_q),
      .ram2_rd_en   (ram2_rd_en),
      .ram2_rd_addr (ram2_rd_addr),
      .ram2_rd_data (ram2_q),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .dout_last    (dout_last),
      .active_bank  (active_bank),
      .err_cnt      (err_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      word_t w;
      free_t f;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", dout_valid, 1);
            check("stall_data", dout, prev_dout);
            check("stall_last", dout_last, prev_last);
         end
         if (dout_valid && dout_ready) begin
            if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", dout, cyc);
            end else begin
               w = sb_q.pop_front();
               check("word_data", dout, w.data);
               check("word_last", dout_last, w.last);
               if (w.cyc >= 0) check("word_cycle", cyc, w.cyc);
            end
         end
         if (bank_free_o != 2'b00) begin
            if (fr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_free: got %0h expected none (cycle %0d)", bank_free_o, cyc);
            end else begin
               f = fr_q.pop_front();
               check("free_val", bank_free_o, f.val);
               if (f.cyc >= 0) check("free_cycle", cyc, f.cyc);
            end
         end
         if (ram1_rd_en || ram2_rd_en) en_cnt++;
         prev_stall = dout_valid && !dout_ready;
         prev_dout  = dout;
         prev_last  = dout_last;
      end
   end

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pulse(input logic [1:0] v, output int t0);
      @(posedge clk); #1;
      bank_full = v;
      t0 = cyc;
      @(posedge clk); #1;
      bank_full = 2'b00;
   endtask

   task automatic push_bank(input logic bank, input int t_first, input int nwords);
      word_t w;
      for (int a = 0; a < nwords; a++) begin
         w.data = bank ? 8'(128 + a) : 8'(a);
         w.last = (a == DEPTH - 1);
         w.cyc  = (t_first < 0) ? -1 : t_first + a;
         sb_q.push_back(w);
      end
   endtask

   task automatic push_free(input logic [1:0] v, input int t);
      free_t f;
      f.val = v;
      f.cyc = t;
      fr_q.push_back(f);
   endtask

   task automatic drain(input string name, input int budget, input bit rnd);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (rnd) dout_ready = 1'($urandom_range(0, 1));
         @(negedge clk); #1;
         if (sb_q.size() == 0 && fr_q.size() == 0) break;
      end
      check({name, "_left"}, sb_q.size() + fr_q.size(), 0);
      sb_q.delete();
      fr_q.delete();
      dout_ready = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t0, t1, e0, exp_err;
      // 1: reset 200 ns, then idle
      rst_n = 1'b0;
      #200;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_valid", dout_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_last", dout_last, 0);
      check("rst_free", bank_free_o, 0);
      check("rst_en", {ram1_rd_en, ram2_rd_en}, 0);
      check("rst_addr", {ram1_rd_addr, ram2_rd_addr}, 0);
      check("rst_active", active_bank, 0);
      check("rst_err", err_cnt, 0);
      check("rst_en_cnt", en_cnt, 0);

      // 2: single RAM1 bank, latency and end-of-bank handling
      pulse(2'b01, t0);
      push_bank(1'b0, t0 + 3, DEPTH);
      push_free(2'b01, t0 + 103);
      drain("t2", 300, 1'b0);
      check("t2_active", active_bank, 1);
      check("t2_valid_after", dout_valid, 0);

      // 3: both banks reported at once
      do_reset(3);
      pulse(2'b11, t0);
      push_bank(1'b0, t0 + 3, DEPTH);
      push_free(2'b01, t0 + 103);
      push_bank(1'b1, t0 + 105, DEPTH);
      push_free(2'b10, t0 + 205);
      drain("t3", 400, 1'b0);
      check("t3_active", active_bank, 0);

      // 4: RAM2 first is held until RAM1 has been read
      do_reset(3);
      e0 = en_cnt;
      pulse(2'b10, t0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t4_no_reads", en_cnt - e0, 0);
      check("t4_no_valid", dout_valid, 0);
      check("t4_active", active_bank, 0);
      pulse(2'b01, t1);
      push_bank(1'b0, t1 + 3, DEPTH);
      push_free(2'b01, t1 + 103);
      push_bank(1'b1, t1 + 105, DEPTH);
      push_free(2'b10, t1 + 205);
      drain("t4", 400, 1'b0);

      // 5: random backpressure
      do_reset(3);
      pulse(2'b01, t0);
      push_bank(1'b0, -1, DEPTH);
      push_free(2'b01, -1);
      drain("t5", 1500, 1'b1);
      check("t5_active", active_bank, 1);

      // 6: overrun, then reset in the middle of the bank
      do_reset(3);
      pulse(2'b01, t0);
      push_bank(1'b0, t0 + 3, 51);
      repeat (2) @(posedge clk);
      pulse(2'b01, t1);
      repeat (3) @(posedge clk);
      @(negedge clk);
`ifdef PP_ERR_CNT_EN
      exp_err = 1;
`else
      exp_err = 0;
`endif
      check("t6_err_cnt", err_cnt, exp_err);
      drain("t6a", 200, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("t6_rst_valid", dout_valid, 0);
      check("t6_rst_en", {ram1_rd_en, ram2_rd_en}, 0);
      check("t6_rst_free", bank_free_o, 0);
      check("t6_rst_err", err_cnt, 0);
      check("t6_rst_dout", dout, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      e0 = en_cnt;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t6_no_restart", en_cnt - e0, 0);
      check("t6_idle_valid", dout_valid, 0);
      pulse(2'b01, t0);
      push_bank(1'b0, t0 + 3, DEPTH);
      push_free(2'b01, t0 + 103);
      drain("t6b", 300, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
